// File: rtl/mpu_loader.sv
// Matrix load engine: turns a row-major element stream into register-file
// writes tagged with (row, column) and the destination register address.
//
// state | meaning
// IDLE  | waiting for a load command; a legal command also writes element (0,0)
// LOAD  | streaming the remaining elements, column first then row
module mpu_loader #(
  parameter int FP              = 32,
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MBITS           = $clog2(M),
  parameter int NBITS           = $clog2(N),
  parameter int MATRIX_REG_SIZE = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [FP-1:0]              element,
  input  logic [MBITS:0]             matrix_m_size,
  input  logic [NBITS:0]             matrix_n_size,
  input  logic [MATRIX_REG_SIZE-1:0] load_addr,
  output logic                       error,
  output logic                       ack,
  output logic                       write_en,
  output logic [MATRIX_REG_SIZE-1:0] reg_load_addr,
  output logic [FP-1:0]              element_out,
  output logic [MBITS:0]             m,
  output logic [NBITS:0]             n
);

  typedef enum logic {IDLE, LOAD} state_t;

  localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
  localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);

  state_t                     state, state_d;
  logic [MBITS:0]             m_size_q, m_size_d;
  logic [NBITS:0]             n_size_q, n_size_d;
  logic [MBITS:0]             row_q, row_d;
  logic [NBITS:0]             col_q, col_d;
  logic                       error_d, ack_d, write_en_d;
  logic [MATRIX_REG_SIZE-1:0] addr_d;
  logic [FP-1:0]              element_d;
  logic [MBITS:0]             m_d;
  logic [NBITS:0]             n_d;
  logic                       size_ok;

  assign size_ok = (matrix_m_size != '0) && (matrix_m_size <= M_MAX) &&
                   (matrix_n_size != '0) && (matrix_n_size <= N_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      m_size_q      <= '0;
      n_size_q      <= '0;
      row_q         <= '0;
      col_q         <= '0;
      error         <= 1'b0;
      ack           <= 1'b0;
      write_en      <= 1'b0;
      reg_load_addr <= '0;
      element_out   <= '0;
      m             <= '0;
      n             <= '0;
    end else begin
      state         <= state_d;
      m_size_q      <= m_size_d;
      n_size_q      <= n_size_d;
      row_q         <= row_d;
      col_q         <= col_d;
      error         <= error_d;
      ack           <= ack_d;
      write_en      <= write_en_d;
      reg_load_addr <= addr_d;
      element_out   <= element_d;
      m             <= m_d;
      n             <= n_d;
    end
  end

  // row_q/col_q hold the index of the element to be sampled this cycle
  always_comb begin
    state_d    = state;
    m_size_d   = m_size_q;
    n_size_d   = n_size_q;
    row_d      = row_q;
    col_d      = col_q;
    error_d    = 1'b0;
    ack_d      = 1'b0;
    write_en_d = 1'b0;
    addr_d     = reg_load_addr;
    element_d  = element_out;
    m_d        = m;
    n_d        = n;
    case (state)
      IDLE: begin
        if (en) begin
          if (size_ok) begin
            m_size_d   = matrix_m_size;
            n_size_d   = matrix_n_size;
            addr_d     = load_addr;
            write_en_d = 1'b1;
            element_d  = element;
            m_d        = '0;
            n_d        = '0;
            if (matrix_m_size == (MBITS+1)'(1) && matrix_n_size == (NBITS+1)'(1)) begin
              ack_d = 1'b1;
            end else begin
              state_d = LOAD;
              if (matrix_n_size == (NBITS+1)'(1)) begin
                row_d = (MBITS+1)'(1);
                col_d = '0;
              end else begin
                row_d = '0;
                col_d = (NBITS+1)'(1);
              end
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      LOAD: begin
        write_en_d = 1'b1;
        element_d  = element;
        m_d        = row_q;
        n_d        = col_q;
        if (col_q == n_size_q - 1'b1) begin
          col_d = '0;
          if (row_q == m_size_q - 1'b1) begin
            ack_d   = 1'b1;
            state_d = IDLE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mpu_loader.sv
// Directed bench for mpu_loader: logs every write/ack/error with its cycle
// number and compares against hand-derived schedules and a captured register file.
module tb_mpu_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] element;
  logic [2:0]  matrix_m_size;
  logic [2:0]  matrix_n_size;
  logic [2:0]  load_addr;
  logic        error, ack, write_en;
  logic [2:0]  reg_load_addr;
  logic [31:0] element_out;
  logic [2:0]  m, n;

  mpu_loader dut (
    .clk(clk), .rst(rst), .en(en), .element(element),
    .matrix_m_size(matrix_m_size), .matrix_n_size(matrix_n_size),
    .load_addr(load_addr), .error(error), .ack(ack), .write_en(write_en),
    .reg_load_addr(reg_load_addr), .element_out(element_out), .m(m), .n(n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          addr;
    int          row;
    int          col;
    logic [31:0] d;
  } wr_t;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  wr_t         wq[$];
  int          ack_q[$];
  int          err_q[$];
  logic [31:0] mem [8][4][4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write_en) begin
      wq.push_back('{cyc, int'(reg_load_addr), int'(m), int'(n), element_out});
      if (m < 3'd4 && n < 3'd4) mem[reg_load_addr][m[1:0]][n[1:0]] = element_out;
    end
    if (ack) ack_q.push_back(cyc);
    if (error) err_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    wq.delete();
    ack_q.delete();
    err_q.delete();
  endtask

  // Called #1 after an edge; returns #1 after the edge that starts cycle S.
  task automatic do_load(input int ms, input int ns, input int addr,
                         input logic [31:0] vals[16], input int en_at, output int t0);
    int cnt;
    cnt = (ms >= 1 && ms <= 4 && ns >= 1 && ns <= 4) ? ms * ns : 1;
    t0 = cyc;
    en = 1'b1;
    matrix_m_size = 3'(ms);
    matrix_n_size = 3'(ns);
    load_addr = 3'(addr);
    element = vals[0];
    for (int k = 1; k < cnt; k++) begin
      @(posedge clk);
      #1;
      en = (k == en_at);
      if (k == en_at) begin
        load_addr = 3'd5;
        matrix_m_size = 3'd1;
        matrix_n_size = 3'd1;
      end
      element = vals[k];
    end
    @(posedge clk);
    #1;
    en = 1'b0;
    element = 32'h0;
  endtask

  task automatic verify(input string tag, input int t0, input int ms, input int ns,
                        input int addr, input logic [31:0] vals[16], input int first);
    int s;
    int found;
    s = ms * ns;
    for (int i = 0; i < s; i++) begin
      if (first + i < wq.size()) begin
        chk($sformatf("%s w%0d cyc", tag, i), 64'(wq[first+i].cyc - t0), 64'(i + 1));
        chk($sformatf("%s w%0d addr", tag, i), 64'(wq[first+i].addr), 64'(addr));
        chk($sformatf("%s w%0d row", tag, i), 64'(wq[first+i].row), 64'(i / ns));
        chk($sformatf("%s w%0d col", tag, i), 64'(wq[first+i].col), 64'(i % ns));
        chk($sformatf("%s w%0d data", tag, i), 64'(wq[first+i].d), 64'(vals[i]));
      end else begin
        chk($sformatf("%s w%0d present", tag, i), 64'(0), 64'(1));
      end
    end
    found = 0;
    foreach (ack_q[j]) if (ack_q[j] == t0 + s) found = 1;
    chk($sformatf("%s ack at cycle %0d", tag, s), 64'(found), 64'(1));
  endtask

  logic [31:0] v[16];
  logic [31:0] v2[16];
  int t0, t1;

  initial begin
    rst = 1'b1;
    en = 1'b0;
    element = 32'h0;
    matrix_m_size = 3'd0;
    matrix_n_size = 3'd0;
    load_addr = 3'd0;
    idle(3);
    chk("rst write_en", 64'(write_en), 64'(0));
    chk("rst ack/error", 64'({ack, error}), 64'(0));
    chk("rst outputs", 64'({reg_load_addr, m, n}), 64'(0));
    chk("rst element_out", 64'(element_out), 64'(0));
    rst = 1'b0;
    idle(2);
    clear_logs();

    // 2x2 to address 0
    foreach (v[i]) v[i] = 32'h0;
    v[0] = 32'h3f800000; v[1] = 32'h424951ec; v[2] = 32'hc0200000; v[3] = 32'h3e000000;
    do_load(2, 2, 0, v, -1, t0);
    idle(3);
    chk("2x2 writes", 64'(wq.size()), 64'(4));
    chk("2x2 acks", 64'(ack_q.size()), 64'(1));
    verify("2x2", t0, 2, 2, 0, v, 0);
    chk("2x2 mat00", 64'(mem[0][0][0]), 64'h3f800000);
    chk("2x2 mat01", 64'(mem[0][0][1]), 64'h424951ec);
    chk("2x2 mat10", 64'(mem[0][1][0]), 64'hc0200000);
    chk("2x2 mat11", 64'(mem[0][1][1]), 64'h3e000000);
    chk("2x2 held element_out", 64'(element_out), 64'h3e000000);
    chk("2x2 held m/n/addr", 64'({reg_load_addr, m, n}), 64'({3'd0, 3'd1, 3'd1}));

    // illegal sizes
    clear_logs();
    do_load(0, 2, 1, v, -1, t0);
    idle(3);
    chk("m0 error count", 64'(err_q.size()), 64'(1));
    if (err_q.size() > 0) chk("m0 error cycle", 64'(err_q[0] - t0), 64'(1));
    chk("m0 writes", 64'(wq.size()), 64'(0));
    chk("m0 acks", 64'(ack_q.size()), 64'(0));
    clear_logs();
    do_load(2, 5, 1, v, -1, t0);
    idle(3);
    chk("n5 error count", 64'(err_q.size()), 64'(1));
    if (err_q.size() > 0) chk("n5 error cycle", 64'(err_q[0] - t0), 64'(1));
    chk("n5 writes", 64'(wq.size()), 64'(0));
    chk("n5 acks", 64'(ack_q.size()), 64'(0));
    clear_logs();
    do_load(5, 1, 1, v, -1, t0);
    idle(3);
    chk("m5 error count", 64'(err_q.size()), 64'(1));
    chk("m5 writes", 64'(wq.size()), 64'(0));

    // full 4x4 to address 7
    clear_logs();
    foreach (v[i]) v[i] = 32'h40000000 + 32'(i * 32'h00010001);
    do_load(4, 4, 7, v, -1, t0);
    idle(3);
    chk("4x4 writes", 64'(wq.size()), 64'(16));
    chk("4x4 acks", 64'(ack_q.size()), 64'(1));
    verify("4x4", t0, 4, 4, 7, v, 0);
    chk("4x4 mat33", 64'(mem[7][3][3]), 64'(v[15]));
    chk("4x4 mat21", 64'(mem[7][2][1]), 64'(v[9]));

    // 1x1 then an immediate 2x1 in the ack cycle
    clear_logs();
    foreach (v[i]) v[i] = 32'h0;
    foreach (v2[i]) v2[i] = 32'h0;
    v[0] = 32'hdeadbeef;
    v2[0] = 32'h3f000000; v2[1] = 32'hbf000000;
    do_load(1, 1, 3, v, -1, t0);
    do_load(2, 1, 4, v2, -1, t1);
    idle(3);
    chk("b2b start cycle", 64'(t1 - t0), 64'(1));
    chk("b2b writes", 64'(wq.size()), 64'(3));
    chk("b2b acks", 64'(ack_q.size()), 64'(2));
    verify("1x1", t0, 1, 1, 3, v, 0);
    verify("2x1", t1, 2, 1, 4, v2, 1);

    // en re-pulsed mid-load must be ignored
    clear_logs();
    foreach (v[i]) v[i] = 32'hc1000000 + 32'(i);
    do_load(3, 3, 6, v, 4, t0);
    idle(4);
    chk("3x3 writes", 64'(wq.size()), 64'(9));
    chk("3x3 acks", 64'(ack_q.size()), 64'(1));
    chk("3x3 errors", 64'(err_q.size()), 64'(0));
    verify("3x3", t0, 3, 3, 6, v, 0);

    // reset in cycle 2 of a 2x2 load
    clear_logs();
    foreach (v[i]) v[i] = 32'h41200000 + 32'(i);
    t0 = cyc;
    en = 1'b1; matrix_m_size = 3'd2; matrix_n_size = 3'd2; load_addr = 3'd2;
    element = v[0];
    idle(1);
    en = 1'b0; element = v[1];
    idle(1);
    rst = 1'b1; element = v[2];
    idle(1);
    chk("rst-abort cycle", 64'(cyc - t0), 64'(3));
    chk("rst-abort write_en", 64'(write_en), 64'(0));
    chk("rst-abort ack", 64'(ack), 64'(0));
    chk("rst-abort element_out", 64'(element_out), 64'(0));
    chk("rst-abort addr/m/n", 64'({reg_load_addr, m, n}), 64'(0));
    rst = 1'b0; element = v[3];
    idle(4);
    chk("rst-abort writes", 64'(wq.size()), 64'(2));
    chk("rst-abort acks", 64'(ack_q.size()), 64'(0));
    clear_logs();
    foreach (v2[i]) v2[i] = 32'h0;
    v2[0] = 32'h11111111; v2[1] = 32'h22222222; v2[2] = 32'h33333333; v2[3] = 32'h44444444;
    do_load(2, 2, 1, v2, -1, t0);
    idle(3);
    chk("post-rst writes", 64'(wq.size()), 64'(4));
    verify("post-rst", t0, 2, 2, 1, v2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mpu_loader.md
# mpu_loader

Matrix load engine of the matrix processing unit (MPU). On a load command it accepts a matrix streamed one floating-point element per cycle in row-major order. It writes each element into the matrix register file at the addressed register, indexed by (row, column). It flags illegal dimensions and signals completion, and sits between the MPU command/memory front end and the register file.

## Interface
- FP, 32: element width in bits (IEEE-754 single).
- M, 4: maximum matrix rows.
- N, 4: maximum matrix columns.
- MBITS, $clog2(M): row size/index MSB; fields are [MBITS:0].
- NBITS, $clog2(N): column size/index MSB; fields are [NBITS:0].
- MATRIX_REG_SIZE, 3: register-file address width.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  load command strobe.
- element  in  FP  streamed input element.
- matrix_m_size  in  MBITS+1  row count of incoming matrix.
- matrix_n_size  in  NBITS+1  column count of incoming matrix.
- load_addr  in  MATRIX_REG_SIZE  destination matrix register.
- error  out  1  one-cycle pulse on rejected command.
- ack  out  1  one-cycle pulse on load completion.
- write_en  out  1  register-file element write strobe.
- reg_load_addr  out  MATRIX_REG_SIZE  register-file destination address.
- element_out  out  FP  element to write.
- m  out  MBITS+1  row index of element_out.
- n  out  NBITS+1  column index of element_out.

## Operation
- States: IDLE, LOAD.
- IDLE, en=0: no action; write_en, ack and error are 0.
- IDLE, en=1, legal sizes: latch matrix_m_size, matrix_n_size and load_addr, and sample element as element (0,0).
  - Legal sizes: 1 ≤ matrix_m_size ≤ M and 1 ≤ matrix_n_size ≤ N.
  - If the total count is 1, remain in IDLE; otherwise go to LOAD.
- IDLE, en=1, illegal sizes: pulse error next cycle, write nothing, remain in IDLE.
- LOAD: sample element every cycle, advancing the column first and then the row.
  - Column wraps to 0 at matrix_n_size-1, and the row increments.
  - After sampling element (m_size-1, n_size-1), return to IDLE.
- en is ignored in LOAD, and inputs other than element are ignored after the latch.
- Each sampled element produces one registered write: write_en=1, element_out=sample, m/n=its indices, reg_load_addr=latched address.
- The element value is passed bit-exact; no arithmetic is performed on it.
- ack=1 in the same cycle as the final write.
- In IDLE the outputs element_out, m, n and reg_load_addr hold their last values.
- Inputs m_size/n_size are not re-checked mid-load.

## Timing
- All outputs are registered.
- Reset values: error=0, ack=0, write_en=0, reg_load_addr=0, element_out=0, m=0, n=0, state IDLE.
- Reset has priority over everything.
- Reset mid-load aborts the load: no further writes, no ack; writes already made stay in the register file.
- Take cycle 0 as the en cycle. The element sampled in cycle k (k=0..S-1, S=m_size·n_size) is written in cycle k+1.
- ack is asserted in cycle S. error is asserted in cycle 1.
- The source must present element k in cycle k.
- A new en is accepted from cycle S (the ack cycle) onward, giving back-to-back loads with no bubble.
- The register file captures the write on the edge ending the write_en cycle. Data is readable from matrix_out one cycle after the final write.

## Test plan
- 2x2 load to address 0 of 1.0, 50.33, -2.5, 0.125 (0x3f800000, 0x424951ec, 0xc0200000, 0x3e000000):
  - writes appear in cycles 1-4 at (0,0),(0,1),(1,0),(1,1);
  - ack in cycle 4;
  - matrix_out shows [[1.0, 50.33], [-2.5, 0.125]].
- en with matrix_m_size=0, or matrix_n_size=N+1 -> error pulse in cycle 1, no write_en, no ack.
- Full MxN load to address 7 with distinct values:
  - exactly M·N writes in row-major order;
  - ack coincides with write (M-1, N-1).
- 1x1 load -> a single write and ack in cycle 1; a second load started in cycle 1 proceeds immediately.
- en pulsed again during a 3x3 load -> ignored; exactly 9 writes to the original address.
- rst asserted in cycle 2 of a 2x2 load -> outputs zero the next cycle, no ack, state IDLE, and a fresh load then completes normally.
